// File: rtl/calc_ctrl.sv
// -----------------------------------------------------------------------------
// calc_ctrl -- control FSM of the 4-digit BCD calculator.
//
// Edge-detects the debounced button levels, sequences operand entry, operator
// selection and a digit-serial BCD add/subtract, and selects the value shown
// on the BCD display mux.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   button_clr/ent/add/sub debounced, synchronized button levels
//   slider_1..slider_4    digit 0..3 edit enables
//   display_bcd[15:0]     four packed BCD digits, [3:0] = ones digit
//   negative              result sign
//   overflow              add result exceeded 9999
//   op_sub                selected operation (0 = add, 1 = sub)
//   busy                  high while the digit-serial CALC runs
//   state_dbg[2:0]        current state encoding
//
// Optional feature: define CALC_AUTOREPEAT_EN to re-issue a held add/sub
// every REPEAT_PERIOD clocks while editing an operand.
// -----------------------------------------------------------------------------
module calc_ctrl #(
    parameter int REPEAT_PERIOD = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        button_clr,
    input  logic        button_ent,
    input  logic        button_add,
    input  logic        button_sub,
    input  logic        slider_1,
    input  logic        slider_2,
    input  logic        slider_3,
    input  logic        slider_4,
    output logic [15:0] display_bcd,
    output logic        negative,
    output logic        overflow,
    output logic        op_sub,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        ENTRY_A = 3'd0,
        OP      = 3'd1,
        ENTRY_B = 3'd2,
        CALC    = 3'd3,
        RESULT  = 3'd4
    } state_t;

    state_t      state, state_n;
    logic [15:0] entry, entry_n, a, a_n, b, b_n, result, result_n;
    logic        negative_n, overflow_n, op_sub_n;
    logic [3:0]  prev;          // previous button levels {clr, ent, add, sub}
    logic [1:0]  dig, dig_n;    // digit index during CALC
    logic        carry, carry_n;

    logic [3:0]  levels, raw_ev;
    logic        rpt_add, rpt_sub;
    logic        ev_clr, ev_ent, ev_add, ev_sub;
    logic [3:0]  sel;

    assign levels = {button_clr, button_ent, button_add, button_sub};
    assign raw_ev = levels & ~prev;
    assign sel    = {slider_4, slider_3, slider_2, slider_1};

`ifdef CALC_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_PERIOD + 1);
    logic [RPT_W-1:0] rpt_cnt;
    logic hold_add, hold_sub, rpt_active, rpt_fire;

    // A held button only repeats when no higher-priority button is down.
    assign hold_add   = button_add & ~button_clr & ~button_ent;
    assign hold_sub   = button_sub & ~button_clr & ~button_ent & ~button_add;
    assign rpt_active = ((state == ENTRY_A) || (state == ENTRY_B)) && (hold_add || hold_sub);
    assign rpt_fire   = rpt_active && (rpt_cnt == RPT_W'(REPEAT_PERIOD - 1));
    assign rpt_add    = rpt_fire & hold_add;
    assign rpt_sub    = rpt_fire & hold_sub;

    always_ff @(posedge clk) begin
        if (reset || !rpt_active || (raw_ev != 4'b0) || rpt_fire) rpt_cnt <= '0;
        else                                                     rpt_cnt <= rpt_cnt + 1'b1;
    end
`else
    logic unused_period;
    assign unused_period = (REPEAT_PERIOD != 0);
    assign rpt_add       = 1'b0;
    assign rpt_sub       = 1'b0;
`endif

    // Only the highest-priority event of a cycle survives.
    assign ev_clr = raw_ev[3];
    assign ev_ent = raw_ev[2] & ~ev_clr;
    assign ev_add = (raw_ev[1] | rpt_add) & ~ev_clr & ~ev_ent;
    assign ev_sub = (raw_ev[0] | rpt_sub) & ~ev_clr & ~ev_ent & ~ev_add;

    // Per-digit modulo-10 increment/decrement, no carry between digits.
    function automatic logic [15:0] edit_digits(input logic [15:0] v,
                                                input logic [3:0]  s,
                                                input logic        up);
        logic [15:0] r;
        logic [3:0]  d;
        r = v;
        for (int i = 0; i < 4; i++) begin
            d = v[i*4 +: 4];
            if (s[i]) begin
                if (up) d = (d == 4'd9) ? 4'd0 : d + 4'd1;
                else    d = (d == 4'd0) ? 4'd9 : d - 4'd1;
            end
            r[i*4 +: 4] = d;
        end
        return r;
    endfunction

    // One BCD digit of the serial add/subtract.
    logic [3:0] a_dig, b_dig, dig_res;
    logic [4:0] sum5, diff5;
    logic       carry_out;

    always_comb begin
        a_dig = a[{dig, 2'b00} +: 4];
        b_dig = b[{dig, 2'b00} +: 4];
        sum5  = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0, carry};
        diff5 = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0, carry};
        if (op_sub) begin
            carry_out = diff5[4];              // borrow: difference went negative
            dig_res   = diff5[4] ? 4'(diff5 + 5'd10) : diff5[3:0];
        end else begin
            carry_out = (sum5 > 5'd9);
            dig_res   = carry_out ? 4'(sum5 - 5'd10) : sum5[3:0];
        end
    end

    // Next-state, datapath and output decode.
    // NOTE: every signal gets its default first so no path can infer a latch.
    always_comb begin
        state_n     = state;
        entry_n     = entry;
        a_n         = a;
        b_n         = b;
        result_n    = result;
        negative_n  = negative;
        overflow_n  = overflow;
        op_sub_n    = op_sub;
        dig_n       = dig;
        carry_n     = carry;
        display_bcd = entry;
        busy        = 1'b0;

        case (state)
            OP:      display_bcd = a;
            CALC: begin
                display_bcd = a;
                busy        = 1'b1;
            end
            RESULT:  display_bcd = result;
            default: display_bcd = entry;
        endcase

        if (ev_clr) begin
            state_n    = ENTRY_A;
            entry_n    = '0;
            a_n        = '0;
            b_n        = '0;
            result_n   = '0;
            negative_n = 1'b0;
            overflow_n = 1'b0;
            op_sub_n   = 1'b0;
        end else begin
            case (state)
                ENTRY_A, ENTRY_B: begin
                    if (ev_ent) begin
                        if (state == ENTRY_A) begin
                            a_n     = entry;
                            entry_n = '0;
                            state_n = OP;
                        end else begin
                            // Subtract always runs larger minus smaller.
                            if (op_sub && (entry > a)) begin
                                a_n        = entry;
                                b_n        = a;
                                negative_n = 1'b1;
                            end else begin
                                b_n = entry;
                            end
                            dig_n   = 2'd0;
                            carry_n = 1'b0;
                            state_n = CALC;
                        end
                    end else if (ev_add) begin
                        entry_n = edit_digits(entry, sel, 1'b1);
                    end else if (ev_sub) begin
                        entry_n = edit_digits(entry, sel, 1'b0);
                    end
                end
                OP: begin
                    if (ev_add || ev_sub) begin
                        op_sub_n = ev_sub;
                        state_n  = ENTRY_B;
                    end
                end
                CALC: begin
                    result_n[{dig, 2'b00} +: 4] = dig_res;
                    carry_n = carry_out;
                    dig_n   = dig + 2'd1;
                    if (dig == 2'd3) begin
                        overflow_n = ~op_sub & carry_out;
                        state_n    = RESULT;
                    end
                end
                RESULT: begin
                    if (ev_ent) begin
                        entry_n    = '0;
                        negative_n = 1'b0;
                        overflow_n = 1'b0;
                        state_n    = ENTRY_A;
                    end else if ((ev_add || ev_sub) && !negative && !overflow) begin
                        a_n      = result;
                        op_sub_n = ev_sub;
                        entry_n  = '0;
                        state_n  = ENTRY_B;
                    end
                end
                default: state_n = ENTRY_A;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ENTRY_A;
            entry    <= '0;
            a        <= '0;
            b        <= '0;
            result   <= '0;
            negative <= 1'b0;
            overflow <= 1'b0;
            op_sub   <= 1'b0;
            prev     <= 4'hF;   // a button held through reset yields no event
            dig      <= 2'd0;
            carry    <= 1'b0;
        end else begin
            state    <= state_n;
            entry    <= entry_n;
            a        <= a_n;
            b        <= b_n;
            result   <= result_n;
            negative <= negative_n;
            overflow <= overflow_n;
            op_sub   <= op_sub_n;
            prev     <= levels;
            dig      <= dig_n;
            carry    <= carry_n;
        end
    end

    assign state_dbg = state;

endmodule
